timer_bank: RTL
===============

# timer_bank

Parametrised bank of N independent down-counting timers behind a single bridge-decoded register window. It is the successor to the fixed pair of TC instances hanging off the bridge. Channel count and counter width are generics, and a per-channel auto-reload mode is added. A sticky, write-1-to-clear pending flag is added per channel, separate from the mask. The per-channel IRQ vector feeds HWInt directly, and `irq_any` serves single-line hookups.

## Interface
Parameters:
- `N_TIMERS`, 2: number of channels, legal range 1..8.
- `WIDTH`, 32: PRESET/COUNT width, legal range 8..32. Register reads are zero-extended to 32 bits.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `sel`  in  1  chip select from the bridge.
- `we`  in  1  write strobe, qualified by `sel`.
- `addr`  in  5  word offset in the window. `addr[4:2]` is the channel, `addr[1:0]` is the register.
- `wdata`  in  32  write data.
- `rdata`  out  32  combinational read data for the current `addr`.
- `irq`  out  N_TIMERS  per-channel interrupt requests.
- `irq_any`  out  1  OR of `irq`.

## Operation
Register map per channel (reg index: meaning):
- 0 CTRL, R/W.
  - bit0 EN.
  - bits2:1 MODE: 00 one-shot, 01 auto-reload, 1x treated as 00.
  - bit3 IM (interrupt mask enable).
  - Other bits read 0.
- 1 PRESET, R/W, low WIDTH bits.
- 2 COUNT, read-only; writes are ignored.
- 3 STATUS: bit0 PEND. Writing 1 clears PEND; writing 0 has no effect.

Reads:
- A channel index ≥ N_TIMERS reads 0, and writes to it are ignored.
- `rdata` = 0 when `sel`=0.

Per-channel FSM (IDLE, LOAD, CNT, INT):
- IDLE: if EN goto LOAD; COUNT holds.
- LOAD: COUNT ← PRESET; goto CNT.
- CNT:
  - if !EN goto IDLE, COUNT holds;
  - else if COUNT > 1, COUNT ← COUNT−1;
  - else COUNT ← 0, goto INT.
- INT: PEND ← 1.
  - Mode 00: EN ← 0, goto IDLE.
  - Mode 01: goto LOAD.

Interrupt outputs:
- `irq[i]` = PEND[i] & IM[i], registered-state driven; there is no combinational path from the bus.
- Clearing IM masks `irq` but leaves PEND set.

Boundary rules:
- PRESET = 0 behaves like PRESET = 1: one CNT cycle, then INT.
- A PRESET write during CNT does not disturb the running COUNT. The new value is taken at the next LOAD.
- A CTRL write with EN=0 during any state stops the channel. From INT it still completes the INT actions this cycle, then IDLE.
- A STATUS clear in the same cycle as INT: the set wins, PEND = 1.
- In mode 00, a CTRL write with EN=1 in the same cycle as INT: the bus write wins and EN stays 1. The FSM goes to IDLE and reloads on the following cycle.
- Counter arithmetic is WIDTH bits, unsigned. It never wraps below 0.

## Timing
Reset values:
- CTRL = 0, PRESET = 0, COUNT = 0, PEND = 0.
- All FSMs are in IDLE.
- `irq` = 0, `irq_any` = 0.
- `rdata` reflects these values.

Bus timing:
- Writes take effect at the rising edge ending the cycle in which `sel & we` are high.
- Reads are same-cycle combinational.

Channel latency, with EN written in cycle 0 and PRESET = P ≥ 1:
- cycle 1: IDLE.
- cycle 2: LOAD.
- cycles 3..P+2: CNT. COUNT reads P down to 1.
- cycle P+3: INT. COUNT = 0.
- cycle P+4: PEND = 1, and `irq` = 1 if IM is set.

Auto-reload period is P+2 cycles (INT → LOAD → P CNT cycles). Each period produces one INT, and PEND stays high until it is cleared.

Reset asserted mid-count returns the channel to the reset state at the next edge regardless of FSM state or bus activity.

## Test plan
- Reset, then read all registers of channels 0..N−1 and an out-of-range channel → every read returns 0, `irq` = 0.
- Ch0: PRESET = 5, then CTRL = 0x9 (EN, one-shot, IM) in cycle 0 → COUNT reads 5,4,3,2,1 in cycles 3–7. INT occurs in cycle 8, `irq[0]` = 1 from cycle 9. CTRL then reads 0x8, and `irq` stays high until STATUS is written 1.
- Ch1: PRESET = 3, CTRL = 0xB (auto-reload, IM) → PEND sets every 5 cycles. Clear STATUS in the same cycle as INT → PEND remains 1.
- Ch0 counting with PRESET = 10: write CTRL = 0 at COUNT = 6 → COUNT holds at 6 or 5 (one decrement may retire first) with no interrupt. Rewrite EN → reload from PRESET and full 10-cycle count.
- IM = 0 with PRESET = 0 → PEND = 1 after 4 cycles, `irq` = 0. Then set IM → `irq` = 1 the next cycle.
- N_TIMERS = 8, WIDTH = 8: all channels run concurrently with distinct presets → `irq_any` is the OR of the channels. Writing PRESET = 0x1FF stores 0xFF.

Source files
------------

// File: rtl/timer_bank.sv
// Bank of N_TIMERS independent down-counting timers behind one register window.
// Each channel has one-shot/auto-reload modes, a sticky W1C pending flag and a mask.
module timer_bank #(
   parameter int unsigned N_TIMERS = 2,
   parameter int unsigned WIDTH    = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sel,
   input  logic                we,
   input  logic [4:0]          addr,
   input  logic [31:0]         wdata,
   output logic [31:0]         rdata,
   output logic [N_TIMERS-1:0] irq,
   output logic                irq_any
);

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PRESET = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;
   localparam logic [1:0] MODE_AUTO  = 2'b01;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

   logic [31:0] w_rd_ch [N_TIMERS];
   logic        w_unused_wdata;

   assign w_unused_wdata = &{1'b0, wdata};

   for (genvar g = 0; g < N_TIMERS; g++) begin : g_ch
      state_t             r_state, w_state_nxt;
      logic               r_en, w_en_nxt;
      logic [1:0]         r_mode, w_mode_nxt;
      logic               r_im, w_im_nxt;
      logic               r_pend, w_pend_nxt;
      logic [WIDTH-1:0]   r_preset, w_preset_nxt;
      logic [WIDTH-1:0]   r_count, w_count_nxt;
      logic               w_hit;

      assign w_hit = sel & we & (addr[4:2] == 3'(g));

      // Bus writes first, then FSM actions; INT's PEND set overrides a same-cycle clear.
      always_comb begin
         w_state_nxt  = r_state;
         w_en_nxt     = r_en;
         w_mode_nxt   = r_mode;
         w_im_nxt     = r_im;
         w_pend_nxt   = r_pend;
         w_preset_nxt = r_preset;
         w_count_nxt  = r_count;

         if (w_hit && addr[1:0] == REG_CTRL) begin
            w_en_nxt   = wdata[0];
            w_mode_nxt = wdata[2:1];
            w_im_nxt   = wdata[3];
         end
         if (w_hit && addr[1:0] == REG_PRESET) w_preset_nxt = wdata[WIDTH-1:0];
         if (w_hit && addr[1:0] == REG_STATUS && wdata[0]) w_pend_nxt = 1'b0;

         case (r_state)
            S_IDLE: if (r_en) w_state_nxt = S_LOAD;
            S_LOAD: begin
               w_count_nxt = r_preset;
               w_state_nxt = S_CNT;
            end
            S_CNT: begin
               if (!r_en) begin
                  w_state_nxt = S_IDLE;
               end else if (r_count > WIDTH'(1)) begin
                  w_count_nxt = r_count - WIDTH'(1);
               end else begin
                  w_count_nxt = '0;
                  w_state_nxt = S_INT;
               end
            end
            S_INT: begin
               w_pend_nxt = 1'b1;
               if (r_mode == MODE_AUTO && w_en_nxt) begin
                  w_state_nxt = S_LOAD;
               end else begin
                  w_state_nxt = S_IDLE;
                  // One-shot self-disables unless the bus rewrites CTRL this cycle.
                  if (r_mode != MODE_AUTO && !(w_hit && addr[1:0] == REG_CTRL))
                     w_en_nxt = 1'b0;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            r_state  <= S_IDLE;
            r_en     <= 1'b0;
            r_mode   <= 2'b00;
            r_im     <= 1'b0;
            r_pend   <= 1'b0;
            r_preset <= '0;
            r_count  <= '0;
         end else begin
            r_state  <= w_state_nxt;
            r_en     <= w_en_nxt;
            r_mode   <= w_mode_nxt;
            r_im     <= w_im_nxt;
            r_pend   <= w_pend_nxt;
            r_preset <= w_preset_nxt;
            r_count  <= w_count_nxt;
         end
      end

      always_comb begin
         case (addr[1:0])
            REG_CTRL:   w_rd_ch[g] = {28'd0, r_im, r_mode, r_en};
            REG_PRESET: w_rd_ch[g] = 32'(r_preset);
            REG_COUNT:  w_rd_ch[g] = 32'(r_count);
            default:    w_rd_ch[g] = {31'd0, r_pend};
         endcase
      end

      assign irq[g] = r_pend & r_im;
   end

   // Out-of-range channels and deselected reads return zero.
   always_comb begin
      rdata = '0;
      if (sel) begin
         for (int i = 0; i < N_TIMERS; i++) begin
            if (addr[4:2] == 3'(i)) rdata = w_rd_ch[i];
         end
      end
   end

   assign irq_any = |irq;

endmodule
